// File: rtl/core_if_pf_if.sv
// -----------------------------------------------------------------------------
// core_if_pf_if
// Instruction-side Wishbone pipelined read bus between the prefetching fetch
// stage (master) and the instruction memory / bus fabric (slave).
//
// Signals:
//   wb_cyc_o   master->slave  bus cycle active
//   wb_stb_o   master->slave  request strobe
//   wb_we_o    master->slave  write enable (reads only, always 0)
//   wb_adr_o   master->slave  request address, ADDR_W bits
//   wb_stall_i slave->master  request not accepted this cycle
//   wb_ack_i   slave->master  read data valid, in request order
//   wb_dat_i   slave->master  read data, DATA_W bits
// -----------------------------------------------------------------------------
interface core_if_pf_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              wb_cyc_o;
   logic              wb_stb_o;
   logic              wb_we_o;
   logic [ADDR_W-1:0] wb_adr_o;
   logic              wb_stall_i;
   logic              wb_ack_i;
   logic [DATA_W-1:0] wb_dat_i;

   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o,
      input  wb_stall_i, wb_ack_i, wb_dat_i
   );

   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o,
      output wb_stall_i, wb_ack_i, wb_dat_i
   );
endinterface

// File: rtl/core_if_pf.sv
// -----------------------------------------------------------------------------
// core_if_pf
// Prefetching instruction-fetch stage. Issues back-to-back Wishbone pipelined
// reads, keeps up to MAX_OUTSTANDING requests in flight and buffers returned
// instructions with their PCs in a FIFO ahead of decode. A set_pc redirect
// flushes the FIFO and drops every response still in flight.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   wb         Wishbone master modport (cyc/stb/we/adr out, stall/ack/dat in)
//   if_halt    decode not consuming this cycle
//   set_pc     redirect request; new_pc is the target (low bits forced 0)
//   if_valid   FIFO head valid
//   if_pc      PC of the head entry (0 when empty)
//   if_instr   head instruction (NOP_INSTR when empty)
// -----------------------------------------------------------------------------
module core_if_pf #(
   parameter int                 ADDR_W          = 32,
   parameter int                 DATA_W          = 32,
   parameter int                 FIFO_DEPTH      = 4,
   parameter int                 MAX_OUTSTANDING = 2,
   parameter logic [ADDR_W-1:0]  RESET_PC        = {ADDR_W{1'b0}},
   parameter logic [5:0]         OPCODE_NOP      = 6'b000000,
   parameter logic [DATA_W-1:0]  NOP_INSTR       = {OPCODE_NOP, {(DATA_W-6){1'b0}}}
) (
   input  logic              clk,
   input  logic              rst,
   core_if_pf_if.master      wb,
   input  logic              if_halt,
   input  logic              set_pc,
   input  logic [ADDR_W-1:0] new_pc,
   output logic              if_valid,
   output logic [ADDR_W-1:0] if_pc,
   output logic [DATA_W-1:0] if_instr
);
   localparam int                PTR_W      = $clog2(FIFO_DEPTH);
   localparam int                CNT_W      = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  MAX_OUT_C  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
   localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
   localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(DATA_W/8);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(DATA_W/8 - 1));

   logic [ADDR_W-1:0] req_pc_r;
   logic [ADDR_W-1:0] resp_pc_r;
   logic [DATA_W-1:0] instr_mem_r [FIFO_DEPTH];
   logic [ADDR_W-1:0] pc_mem_r    [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  outstanding_r;
   logic [CNT_W-1:0]  discard_r;

   logic [CNT_W:0]    credit_sum_s;
   logic              issue_s;
   logic              accept_s;
   logic              ack_s;
   logic              push_s;
   logic              pop_s;
   logic [CNT_W-1:0]  outstanding_nxt_s;
   logic [CNT_W-1:0]  count_nxt_s;
   logic [CNT_W-1:0]  discard_nxt_s;
   logic [ADDR_W-1:0] target_pc_s;

   // Issue/accept/ack/push/pop decisions and next counter values.
   always_comb begin
      credit_sum_s      = {1'b0, count_r} + {1'b0, outstanding_r};
      issue_s           = 1'b0;
      accept_s          = 1'b0;
      ack_s             = 1'b0;
      push_s            = 1'b0;
      pop_s             = 1'b0;
      outstanding_nxt_s = outstanding_r;
      count_nxt_s       = count_r;
      discard_nxt_s     = discard_r;
      target_pc_s       = new_pc & ALIGN_MASK;

      // Credits cover both buffered and in-flight entries, so a push can
      // never meet a full FIFO.
      if (!rst && (outstanding_r < MAX_OUT_C) && (credit_sum_s < {1'b0, DEPTH_C})) begin
         issue_s = 1'b1;
      end else begin
         issue_s = 1'b0;
      end
      accept_s = issue_s && !wb.wb_stall_i;
      // An ack with nothing in flight is ignored to keep the counter sane.
      ack_s    = wb.wb_ack_i && (outstanding_r != CNT_ZERO);

      if (ack_s && (discard_r != CNT_ZERO)) begin
         discard_nxt_s = discard_r - CNT_ONE;
         push_s        = 1'b0;
      end else begin
         discard_nxt_s = discard_r;
         // A redirect drops the ack arriving in the same cycle.
         push_s        = ack_s && !set_pc;
      end
      pop_s = (count_r != CNT_ZERO) && !if_halt && !set_pc;

      case ({accept_s, ack_s})
         2'b10:   outstanding_nxt_s = outstanding_r + CNT_ONE;
         2'b01:   outstanding_nxt_s = outstanding_r - CNT_ONE;
         default: outstanding_nxt_s = outstanding_r;
      endcase

      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Control state: request/response PCs, FIFO pointers and bus counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_pc_r      <= RESET_PC;
         resp_pc_r     <= RESET_PC;
         wr_ptr_r      <= {PTR_W{1'b0}};
         rd_ptr_r      <= {PTR_W{1'b0}};
         count_r       <= CNT_ZERO;
         outstanding_r <= CNT_ZERO;
         discard_r     <= CNT_ZERO;
      end else begin
         outstanding_r <= outstanding_nxt_s;
         if (set_pc) begin
            // Everything still in flight after this edge belongs to the old
            // stream, including a request accepted in this very cycle.
            req_pc_r  <= target_pc_s;
            resp_pc_r <= target_pc_s;
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= CNT_ZERO;
            discard_r <= outstanding_nxt_s;
         end else begin
            if (accept_s) begin
               req_pc_r <= req_pc_r + PC_STEP;
            end
            if (push_s) begin
               resp_pc_r <= resp_pc_r + PC_STEP;
               wr_ptr_r  <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r   <= count_nxt_s;
            discard_r <= discard_nxt_s;
         end
      end
   end

   // FIFO storage; the response PC counter tags each kept instruction.
   always_ff @(posedge clk) begin
      if (push_s && !rst) begin
         instr_mem_r[wr_ptr_r] <= wb.wb_dat_i;
         pc_mem_r[wr_ptr_r]    <= resp_pc_r;
      end
   end

   assign wb.wb_stb_o = issue_s;
   assign wb.wb_cyc_o = !rst && (issue_s || (outstanding_r != CNT_ZERO));
   assign wb.wb_we_o  = 1'b0;
   assign wb.wb_adr_o = rst ? RESET_PC : req_pc_r;

   assign if_valid = !rst && (count_r != CNT_ZERO);
   assign if_pc    = if_valid ? pc_mem_r[rd_ptr_r]    : {ADDR_W{1'b0}};
   assign if_instr = if_valid ? instr_mem_r[rd_ptr_r] : NOP_INSTR;
endmodule

// File: tb/tb_core_if_pf.sv
module tb_core_if_pf;
   localparam int          AW  = 32;
   localparam int          DW  = 32;
   localparam logic [31:0] RPC = 32'h0000_0100;
   localparam logic [31:0] NOP = 32'hA800_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_halt;
   logic        set_pc;
   logic [31:0] new_pc;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   always #5 clk = ~clk;

   core_if_pf_if #(.ADDR_W(AW), .DATA_W(DW)) wb ();

   core_if_pf #(
      .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2),
      .RESET_PC(RPC), .NOP_INSTR(NOP)
   ) dut (
      .clk(clk), .rst(rst), .wb(wb.master),
      .if_halt(if_halt), .set_pc(set_pc), .new_pc(new_pc),
      .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
   );

   typedef struct { logic [31:0] addr; int tag; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

   req_t        pend_q[$];
   exp_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          epoch    = 0;
   logic [31:0] exp_req_pc = RPC;
   bit          ack_hold = 1'b0;
   logic        nxt_ack  = 1'b0;
   logic [31:0] nxt_addr = 32'h0;
   int          nxt_tag  = 0;
   int          ack_tag  = 0;
   logic [31:0] ack_addr = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Slave driver: presents the ack decided at the previous falling edge.
   initial begin
      wb.wb_ack_i   = 1'b0;
      wb.wb_dat_i   = 32'h0;
      wb.wb_stall_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         wb.wb_ack_i = nxt_ack;
         wb.wb_dat_i = nxt_ack ? mem_word(nxt_addr) : 32'hDEAD_BEEF;
         ack_tag     = nxt_tag;
         ack_addr    = nxt_addr;
      end
   end

   // Scoreboard, slave model and request-address checks on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      req_t r;
      if (rst) begin
         pend_q.delete();
         exp_q.delete();
         exp_req_pc = RPC;
         epoch      = epoch + 1;
         nxt_ack    = 1'b0;
      end else begin
         checks++;
         if (if_valid !== (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL sb_valid got %b want %b at %0t", if_valid, (exp_q.size() != 0), $time);
         end
         if (exp_q.size() != 0) begin
            e = exp_q[0];
            checks++;
            if (if_pc !== e.pc || if_instr !== e.instr) begin
               failures++;
               $display("FAIL sb_head got pc=%h instr=%h want pc=%h instr=%h", if_pc, if_instr, e.pc, e.instr);
            end
            if (if_valid && !if_halt && !set_pc) void'(exp_q.pop_front());
         end else begin
            checks++;
            if (if_pc !== 32'h0 || if_instr !== NOP) begin
               failures++;
               $display("FAIL sb_empty got pc=%h instr=%h want pc=0 instr=%h", if_pc, if_instr, NOP);
            end
         end
         if (wb.wb_stb_o && !wb.wb_stall_i) begin
            checks++;
            if (wb.wb_adr_o !== exp_req_pc) begin
               failures++;
               $display("FAIL req_adr got %h want %h", wb.wb_adr_o, exp_req_pc);
            end
            r.addr = wb.wb_adr_o;
            r.tag  = epoch;
            pend_q.push_back(r);
            exp_req_pc = exp_req_pc + 32'd4;
         end
         if (wb.wb_ack_i && ack_tag == epoch && !set_pc) begin
            e.pc    = ack_addr;
            e.instr = mem_word(ack_addr);
            exp_q.push_back(e);
         end
         if (set_pc) begin
            exp_q.delete();
            epoch      = epoch + 1;
            exp_req_pc = new_pc & 32'hFFFF_FFFC;
         end
         if (!ack_hold && pend_q.size() != 0) begin
            r        = pend_q.pop_front();
            nxt_ack  = 1'b1;
            nxt_addr = r.addr;
            nxt_tag  = r.tag;
         end else begin
            nxt_ack = 1'b0;
         end
      end
   end

   task automatic drive_step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_first_valid(input logic [31:0] want, input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (if_valid) begin
            seen = 1'b1;
            checks++;
            if (if_pc !== want) begin
               failures++;
               $display("FAIL %s got %h want %h", name, if_pc, want);
            end
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout got no valid want pc %h", name, want);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; if_halt = 1'b0; set_pc = 1'b0; new_pc = 32'h0;
      repeat (2) @(negedge clk);
      checks++;
      if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0 || wb.wb_we_o !== 1'b0 ||
          wb.wb_adr_o !== RPC || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== NOP) begin
         failures++;
         $display("FAIL reset_outputs got cyc=%b stb=%b we=%b adr=%h v=%b pc=%h instr=%h want 0 0 0 %h 0 0 %h",
                  wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_adr_o, if_valid, if_pc, if_instr, RPC, NOP);
      end
      drive_step();
      rst = 1'b0;
   endtask

   task automatic test_stream();
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         checks++;
         if (wb.wb_stb_o !== 1'b1 || wb.wb_adr_o !== RPC + 32'(4 * (i - 1))) begin
            failures++;
            $display("FAIL stream_adr got stb=%b adr=%h want stb=1 adr=%h", wb.wb_stb_o, wb.wb_adr_o, RPC + 32'(4 * (i - 1)));
         end
         if (i >= 3) begin
            checks++;
            if (if_valid !== 1'b1 || if_pc !== RPC + 32'(4 * (i - 3))) begin
               failures++;
               $display("FAIL stream_pc got v=%b pc=%h want v=1 pc=%h", if_valid, if_pc, RPC + 32'(4 * (i - 3)));
            end
         end
      end
   endtask

   task automatic test_halt();
      drive_step();
      if_halt = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || wb.wb_stb_o !== 1'b0 || wb.wb_cyc_o !== 1'b0) begin
         failures++;
         $display("FAIL halt_full got v=%b stb=%b cyc=%b want 1 0 0", if_valid, wb.wb_stb_o, wb.wb_cyc_o);
      end
      drive_step();
      if_halt = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_redirect();
      drive_step();
      ack_hold = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (wb.wb_stb_o !== 1'b0 || wb.wb_cyc_o !== 1'b1) begin
         failures++;
         $display("FAIL redir_outstanding got stb=%b cyc=%b want 0 1", wb.wb_stb_o, wb.wb_cyc_o);
      end
      drive_step();
      set_pc = 1'b1; new_pc = 32'h0000_0203; ack_hold = 1'b0;
      drive_step();
      set_pc = 1'b0;
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b0 || wb.wb_adr_o !== 32'h0000_0200) begin
         failures++;
         $display("FAIL redir_next got v=%b adr=%h want v=0 adr=00000200", if_valid, wb.wb_adr_o);
      end
      wait_first_valid(32'h0000_0200, "redir_first_pc");
      repeat (4) @(negedge clk);
   endtask

   task automatic test_redirect_ack_accept();
      drive_step();
      set_pc = 1'b1; new_pc = 32'h0000_0400;
      @(negedge clk);
      checks++;
      if (wb.wb_stb_o !== 1'b1 || wb.wb_ack_i !== 1'b1) begin
         failures++;
         $display("FAIL redir_same_cycle got stb=%b ack=%b want 1 1", wb.wb_stb_o, wb.wb_ack_i);
      end
      drive_step();
      set_pc = 1'b0;
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b0) begin
         failures++;
         $display("FAIL redir2_empty got v=%b want 0", if_valid);
      end
      wait_first_valid(32'h0000_0400, "redir2_first_pc");
      repeat (4) @(negedge clk);
   endtask

   task automatic test_stall();
      logic [31:0] held;
      drive_step();
      wb.wb_stall_i = 1'b1;
      held = exp_req_pc;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (wb.wb_stb_o !== 1'b1 || wb.wb_adr_o !== held) begin
            failures++;
            $display("FAIL stall_hold got stb=%b adr=%h want 1 %h", wb.wb_stb_o, wb.wb_adr_o, held);
         end
      end
      drive_step();
      wb.wb_stall_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (wb.wb_adr_o !== held + 32'd4) begin
         failures++;
         $display("FAIL stall_resume got %h want %h", wb.wb_adr_o, held + 32'd4);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_rst_mid();
      drive_step();
      if_halt = 1'b1;
      repeat (3) @(negedge clk);
      drive_step();
      ack_hold = 1'b1;
      repeat (3) @(negedge clk);
      drive_step();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (wb.wb_cyc_o !== 1'b0 || wb.wb_stb_o !== 1'b0 || wb.wb_adr_o !== RPC ||
          if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== NOP) begin
         failures++;
         $display("FAIL rst_mid_outputs got cyc=%b stb=%b adr=%h v=%b pc=%h instr=%h",
                  wb.wb_cyc_o, wb.wb_stb_o, wb.wb_adr_o, if_valid, if_pc, if_instr);
      end
      drive_step();
      rst = 1'b0; if_halt = 1'b0; ack_hold = 1'b0;
      @(negedge clk);
      checks++;
      if (wb.wb_stb_o !== 1'b1 || wb.wb_adr_o !== RPC || if_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_restart got stb=%b adr=%h v=%b want 1 %h 0", wb.wb_stb_o, wb.wb_adr_o, if_valid, RPC);
      end
      wait_first_valid(RPC, "rst_first_pc");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) begin
         drive_step();
         if_halt       = ($urandom_range(0, 3) == 0);
         wb.wb_stall_i = ($urandom_range(0, 4) == 0);
         ack_hold      = ($urandom_range(0, 4) == 0);
         set_pc        = ($urandom_range(0, 12) == 0);
         new_pc        = 32'h0000_1000 + 32'($urandom_range(0, 255));
      end
      drive_step();
      if_halt = 1'b0; wb.wb_stall_i = 1'b0; ack_hold = 1'b0; set_pc = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_halt();
      test_redirect();
      test_redirect_ack_accept();
      test_stall();
      test_rst_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
